// File: rtl/alu_result_serializer.sv
// Captures six parallel ALU results in one handshake and replays the ones selected
// by a mask as a tagged valid/ready stream, lowest tag first, one result per beat.
module alu_result_serializer #(
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [5:0]            sel_mask,
    input  logic [DATA_WIDTH-1:0] a_plus_b,
    input  logic [DATA_WIDTH-1:0] a_minus_b,
    input  logic [DATA_WIDTH-1:0] not_a,
    input  logic [DATA_WIDTH-1:0] a_and_b,
    input  logic [DATA_WIDTH-1:0] a_or_b,
    input  logic [DATA_WIDTH-1:0] a_xor_b,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [2:0]            out_tag,
    output logic                  out_last,
    output logic [15:0]           txn_count
);

    typedef enum logic {IDLE, SEND} state_t;

    state_t                state_p0, state_nxt;
    logic [DATA_WIDTH-1:0] res_p0 [6];
    logic [5:0]            mask_p0;
    logic [15:0]           txn_p0;
    logic [2:0]            idx;
    logic                  no_more;
    logic                  beat_acc;
    logic                  capture;

    function automatic logic [2:0] lowest_idx(input logic [5:0] m);
        logic [2:0] r;
        r = 3'd0;
        for (int i = 5; i >= 0; i--) begin
            if (m[i]) r = 3'(i);
        end
        return r;
    endfunction

    function automatic logic [5:0] clear_lowest(input logic [5:0] m);
        return m & (m - 6'd1);
    endfunction

    always_comb begin
        idx       = lowest_idx(mask_p0);
        no_more   = (clear_lowest(mask_p0) == 6'd0);
        out_valid = (state_p0 == SEND);
        out_tag   = out_valid ? idx : 3'd0;
        out_last  = out_valid && no_more;
        out_data  = '0;
        if (out_valid) begin
            case (idx)
                3'd0:    out_data = res_p0[0];
                3'd1:    out_data = res_p0[1];
                3'd2:    out_data = res_p0[2];
                3'd3:    out_data = res_p0[3];
                3'd4:    out_data = res_p0[4];
                3'd5:    out_data = res_p0[5];
                default: out_data = '0;
            endcase
        end
        beat_acc  = out_valid && out_ready;
        // A new set may be taken in the same cycle the final beat leaves.
        in_ready  = (state_p0 == IDLE) || (beat_acc && out_last);
        capture   = in_valid && in_ready;
        txn_count = txn_p0;
    end

    always_comb begin
        state_nxt = state_p0;
        if (capture) begin
            state_nxt = (sel_mask != 6'd0) ? SEND : IDLE;
        end else if (beat_acc && out_last) begin
            state_nxt = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) state_p0 <= IDLE;
        else       state_p0 <= state_nxt;
    end

    // Capture / pending-mask / transaction-counter stage
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 6; i++) res_p0[i] <= '0;
            mask_p0 <= 6'd0;
            txn_p0  <= 16'd0;
        end else begin
            if (beat_acc) begin
                mask_p0 <= clear_lowest(mask_p0);
                if (out_last) txn_p0 <= txn_p0 + 16'd1;
            end
            if (capture) begin
                res_p0[0] <= a_plus_b;
                res_p0[1] <= a_minus_b;
                res_p0[2] <= not_a;
                res_p0[3] <= a_and_b;
                res_p0[4] <= a_or_b;
                res_p0[5] <= a_xor_b;
                mask_p0   <= sel_mask;
            end
        end
    end

endmodule
